// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; fixed 34-cycle latency.
// Define MULDIV_DIV_EN to compile in the divider; otherwise ops 2/3 are ignored.
//
// state  | meaning
// IDLE   | waiting for start, MTHI/MTLO writes accepted
// CALC   | one shift-add / shift-subtract iteration per cycle, down-counter to zero
// FIX    | sign correction and HI/LO write
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [5:0]         r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_op_ok;
    logic               w_launch;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_op_ok = 1'b1;

    // Restoring step: remainder lives in the upper half, quotient shifts in at the bottom.
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_div_next = w_div_diff[WIDTH]
                      ? {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_step     = r_div ? w_div_next : w_mul_next;
`else
    assign w_op_ok = ~bus.op[1];
    assign w_step  = w_mul_next;
`endif

    assign w_launch = (r_state == S_IDLE) && bus.start && w_op_ok;
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;

    // Multiplier bits are consumed from the bottom of the accumulator as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_q        = r_acc[WIDTH-1:0];
    assign w_r        = r_acc[2*WIDTH-1:WIDTH];
    // Divide by zero yields all-ones from the restoring loop; the sign fix must not touch it.
    assign w_q_fix    = r_div0 ? '1 : (r_neg_q ? (~w_q + 1'b1) : w_q);
    assign w_r_fix    = r_neg_r ? (~w_r + 1'b1) : w_r;
    assign w_fix_hi   = r_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd  <= w_b_mag;
                        r_div   <= bus.op[1];
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div0  <= (bus.b == '0);
                        r_cnt   <= 6'(WIDTH);
                        r_state <= S_CALC;
                    end else begin
                        if (bus.wr_hi) r_hi <= bus.wr_data;
                        if (bus.wr_lo) r_lo <= bus.wr_data;
                    end
                end
                S_CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model compared every cycle plus literal checks.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit op_ok(input logic [1:0] op);
`ifdef MULDIV_DIV_EN
        return 1'b1;
`else
        return ~op[1];
`endif
    endfunction

    // Returns {HI, LO} straight from the architectural result rules.
    function automatic logic [63:0] expect_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sa, sb, q, r;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'd1: return {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [63:0] p_res = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_res[63:32];
                    m_lo   <= p_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (bus.start && op_ok(bus.op)) begin
                p_res <= expect_res(bus.op, bus.a, bus.b);
                m_cnt <= 34;
            end else begin
                if (bus.wr_hi) m_hi <= bus.wr_data;
                if (bus.wr_lo) m_lo <= bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        n_cmp += 4;
        if (bus.busy !== (m_cnt != 0)) begin
            n_err++;
            $display("FAIL model busy @%0t: got %b want %b", $time, bus.busy, (m_cnt != 0));
        end
        if (bus.done !== m_done) begin
            n_err++;
            $display("FAIL model done @%0t: got %b want %b", $time, bus.done, m_done);
        end
        if (bus.hi !== m_hi) begin
            n_err++;
            $display("FAIL model hi @%0t: got %h want %h", $time, bus.hi, m_hi);
        end
        if (bus.lo !== m_lo) begin
            n_err++;
            $display("FAIL model lo @%0t: got %h want %h", $time, bus.lo, m_lo);
        end
    end

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        lit({nm, " latency"}, n, 35);
        lit({nm, " hi"}, bus.hi, eh);
        lit({nm, " lo"}, bus.lo, el);
    endtask

    initial begin
        int  n;
        bit  seen;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.a       = '0;
        bus.b       = '0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        lit("reset hi", bus.hi, 0);
        lit("reset lo", bus.lo, 0);
        lit("reset busy", bus.busy, 0);
        lit("reset done", bus.done, 0);
        reset_n = 1'b1;

        @(negedge clk);
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        lit("mthi hi", bus.hi, 32'hDEAD_BEEF);
        lit("mthi done", bus.done, 0);
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        @(negedge clk);
        lit("mtlo lo", bus.lo, 32'h0000_1234);
        bus.wr_lo = 1'b0;

        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        lit("mid-op busy", bus.busy, 1);
        #1 reset_n = 1'b0;
        #1;
        lit("abort busy", bus.busy, 0);
        lit("abort hi", bus.hi, 0);
        lit("abort lo", bus.lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu b2b");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult minmin");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "multu maxmax");
        run_op(2'd0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0, "mult neg");

        // start wins over a same-cycle MTHI; later start and MTLO are dropped while busy
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'd0;
        bus.a       = 32'd7;
        bus.b       = 32'd6;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h1111_1111;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        repeat (5) @(negedge clk);
        lit("hold hi", bus.hi, 32'hFFFF_FFFF);
        bus.start   = 1'b1;
        bus.op      = 2'd1;
        bus.a       = 32'hFFFF_FFFF;
        bus.b       = 32'hFFFF_FFFF;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        lit("hold lo", bus.lo, 32'h0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        lit("ignore done seen", seen, 1);
        lit("ignore hi", bus.hi, 32'h0);
        lit("ignore lo", bus.lo, 32'd42);
        @(negedge clk);
        lit("ignore no restart", bus.busy, 0);

`ifdef MULDIV_DIV_EN
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div neg");
        run_op(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu by0");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div ovf");
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div by0");
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
        run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, "div negdiv");
`else
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = 32'hFFFF_FFF9;
        bus.b     = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy || bus.done) seen = 1'b1;
            @(negedge clk);
        end
        lit("nodiv busy/done", seen, 0);
        lit("nodiv hi", bus.hi, 32'h0);
        lit("nodiv lo", bus.lo, 32'd42);
        run_op(2'd1, 32'd9, 32'd9, 32'd0, 32'd81, "nodiv multu");
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
